gpio_arbiter: RTL and testbench

Two-master arbiter and access sequencer for the memory-mapped GPIO register block. It sits between the processor's MEM-stage GPIO port (master 0) and a secondary master such as the debug/loader unit (master 1). It grants one access at a time round-robin and drives the GPIO address/write-enable/write-data lines for exactly one cycle per access. It returns read data with a one-cycle ready pulse to the winning master.

---
 rtl/gpio_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 21 ++
 rtl/gpio_arbiter.sv | 107 ++++++++++
 tb/tb_gpio_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared types and constants for the GPIO two-master arbiter
package gpio_arb_pkg;

    localparam int GPIO_DW = 32;
    localparam int GPIO_AW = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [1:0] GPIO_IN1  = 2'b00;
    localparam logic [1:0] GPIO_IN2  = 2'b01;
    localparam logic [1:0] GPIO_OUT1 = 2'b10;
    localparam logic [1:0] GPIO_OUT2 = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       any
);

    always_comb begin
        any    = |req;
        gnt_id = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            // On a tie the master that was not served last wins.
            2'b11:   gnt_id = ~last;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/gpio_arbiter.sv
// rtl/gpio_arbiter.sv - two-master round-robin arbiter and access sequencer for the GPIO block
module gpio_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int DW = GPIO_DW,
    parameter int AW = GPIO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] a0,
    input  logic [DW-1:0] wd0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] wd1,
    output logic          rdy0,
    output logic          rdy1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic [AW-1:0] gpio_a,
    output logic          gpio_we,
    output logic [DW-1:0] gpio_wd,
    input  logic [DW-1:0] gpio_rd
);

    state_t        state_q;
    state_t        state_d;
    logic          gnt_id;
    logic          any;
    logic          gnt_q;
    logic          last_q;
    logic [DW-1:0] rd_q;

    rr_arb2 u_pick (
        .req    ({req1, req0}),
        .last   (last_q),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // gpio_we is loaded one edge early so it is a clean registered pulse in ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            gpio_a  <= '0;
            gpio_we <= 1'b0;
            gpio_wd <= '0;
            rd_q    <= '0;
            rdy0    <= 1'b0;
            rdy1    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy0 <= 1'b0;
                    rdy1 <= 1'b0;
                    if (any) begin
                        gnt_q   <= gnt_id;
                        gpio_a  <= gnt_id ? a1  : a0;
                        gpio_we <= gnt_id ? we1 : we0;
                        gpio_wd <= gnt_id ? wd1 : wd0;
                    end
                end
                ACCESS: begin
                    gpio_we <= 1'b0;
                    rd_q    <= gpio_rd;
                    rdy0    <= ~gnt_q;
                    rdy1    <= gnt_q;
                end
                DONE: begin
                    rdy0   <= 1'b0;
                    rdy1   <= 1'b0;
                    last_q <= gnt_q;
                end
                default: begin
                    gpio_we <= 1'b0;
                    rdy0    <= 1'b0;
                    rdy1    <= 1'b0;
                end
            endcase
        end
    end

    assign rd0 = rd_q;
    assign rd1 = rd_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb/tb_gpio_arbiter.sv - directed vector bench for gpio_arbiter
module tb_gpio_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [1:0]  a0, a1;
    logic [31:0] wd0, wd1;
    logic        rdy0, rdy1;
    logic [31:0] rd0, rd1;
    logic [1:0]  gpio_a;
    logic        gpio_we;
    logic [31:0] gpio_wd;
    logic [31:0] gpio_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Fixed GPIO read-mux contents.
    always_comb begin
        case (gpio_a)
            2'b00:   gpio_rd = 32'h0000_00A5;
            2'b01:   gpio_rd = 32'h5A5A_0001;
            2'b10:   gpio_rd = 32'h1234_5678;
            default: gpio_rd = 32'hCAFE_F00D;
        endcase
    end

    gpio_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .we0     (we0),
        .a0      (a0),
        .wd0     (wd0),
        .req1    (req1),
        .we1     (we1),
        .a1      (a1),
        .wd1     (wd1),
        .rdy0    (rdy0),
        .rdy1    (rdy1),
        .rd0     (rd0),
        .rd1     (rd1),
        .gpio_a  (gpio_a),
        .gpio_we (gpio_we),
        .gpio_wd (gpio_wd),
        .gpio_rd (gpio_rd)
    );

    typedef struct {
        logic        r0;
        logic        w0;
        logic [1:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [1:0]  a1;
        logic [31:0] d1;
        logic        id;
        logic        we;
        logic [1:0]  ea;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_all();
        req0 = 1'b0; we0 = 1'b0; a0 = 2'b00; wd0 = '0;
        req1 = 1'b0; we1 = 1'b0; a1 = 2'b00; wd1 = '0;
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at a negedge in IDLE.
    task automatic run_vec(input vec_t v);
        req0 = v.r0; we0 = v.w0; a0 = v.a0; wd0 = v.d0;
        req1 = v.r1; we1 = v.w1; a1 = v.a1; wd1 = v.d1;
        @(negedge clk);
        chk("acc_gpio_we", 32'(gpio_we), 32'(v.we));
        chk("acc_gpio_a", 32'(gpio_a), 32'(v.ea));
        chk("acc_gpio_wd", gpio_wd, v.ewd);
        chk("acc_no_rdy", 32'(rdy0 | rdy1), 32'd0);
        @(negedge clk);
        chk("done_rdy0", 32'(rdy0), 32'(v.id == 1'b0));
        chk("done_rdy1", 32'(rdy1), 32'(v.id == 1'b1));
        chk("done_rd0", rd0, v.erd);
        chk("done_rd1", rd1, v.erd);
        chk("done_we_low", 32'(gpio_we), 32'd0);
        drop_all();
        @(negedge clk);
        chk("idle_we_low", 32'(gpio_we), 32'd0);
        chk("idle_rdy_low", 32'(rdy0 | rdy1), 32'd0);
    endtask

    initial begin
        // r0 w0 a0 d0 | r1 w1 a1 d1 | id we ea ewd erd
        vecs[0] = '{1'b1, 1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 32'h0,
                    1'b0, 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[1] = '{1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 2'b00, 32'h1111_1111,
                    1'b1, 1'b0, 2'b00, 32'h1111_1111, 32'h0000_00A5};
        vecs[2] = '{1'b1, 1'b1, 2'b01, 32'h0000_FFFF, 1'b0, 1'b0, 2'b00, 32'h0,
                    1'b0, 1'b1, 2'b01, 32'h0000_FFFF, 32'h5A5A_0001};
        // Tie after master 0 was served: master 1 wins.
        vecs[3] = '{1'b1, 1'b1, 2'b11, 32'hAAAA_0000, 1'b1, 1'b0, 2'b10, 32'hBBBB_0000,
                    1'b1, 1'b0, 2'b10, 32'hBBBB_0000, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 2'b11, 32'hCCCC_0001, 1'b1, 1'b1, 2'b00, 32'hDDDD_0002,
                    1'b0, 1'b1, 2'b11, 32'hCCCC_0001, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 2'b11, 32'h0102_0304,
                    1'b1, 1'b1, 2'b11, 32'h0102_0304, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 32'h5555_5555, 1'b0, 1'b0, 2'b00, 32'h0,
                    1'b0, 1'b0, 2'b00, 32'h5555_5555, 32'h0000_00A5};

        rst = 1'b1;
        drop_all();
        @(negedge clk);
        chk("rst_gpio_a", 32'(gpio_a), 32'd0);
        chk("rst_gpio_we", 32'(gpio_we), 32'd0);
        chk("rst_gpio_wd", gpio_wd, 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_rdy", 32'({rdy1, rdy0}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a write access: abort with no rdy.
        req0 = 1'b1; we0 = 1'b1; a0 = 2'b10; wd0 = 32'h7777_7777;
        @(negedge clk);
        chk("abort_we_before", 32'(gpio_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_we", 32'(gpio_we), 32'd0);
        chk("abort_a", 32'(gpio_a), 32'd0);
        chk("abort_wd", gpio_wd, 32'd0);
        chk("abort_rd", rd0, 32'd0);
        chk("abort_rdy", 32'({rdy1, rdy0}), 32'd0);
        drop_all();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_rdy", 32'({rdy1, rdy0}), 32'd0);
        // Last grant before reset was master 0; after reset master 0 still wins the tie.
        req0 = 1'b1; a0 = 2'b10; req1 = 1'b1; a1 = 2'b01;
        @(negedge clk);
        chk("post_rst_tie_a", 32'(gpio_a), 32'(2'b10));
        @(negedge clk);
        chk("post_rst_tie_rdy", 32'({rdy1, rdy0}), 32'b01);
        drop_all();
        @(negedge clk);

        // Request dropped during ACCESS still completes.
        req0 = 1'b1; we0 = 1'b1; a0 = 2'b11; wd0 = 32'h0BAD_F00D;
        @(negedge clk);
        drop_all();
        chk("drop_we", 32'(gpio_we), 32'd1);
        @(negedge clk);
        chk("drop_rdy0", 32'(rdy0), 32'd1);
        chk("drop_rd0", rd0, 32'hCAFE_F00D);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("drop_idle_we", 32'(gpio_we), 32'd0);
            chk("drop_idle_rdy", 32'({rdy1, rdy0}), 32'd0);
        end

        // Continuous contention; last served was master 0 so master 1 goes first.
        begin
            logic exp_order [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
            int n = 0;
            req0 = 1'b1; a0 = 2'b00; req1 = 1'b1; a1 = 2'b01;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (rdy0 && rdy1) chk("cont_both_rdy", 32'd1, 32'd0);
                if (rdy0 || rdy1) begin
                    if (n < 4) begin
                        chk("cont_order", 32'(rdy1), 32'(exp_order[n]));
                        chk("cont_cycle", 32'(c), 32'(1 + 3 * n));
                    end
                    n++;
                end
                if (c == 11) drop_all();
            end
            chk("cont_count", 32'(n), 32'd4);
            @(negedge clk);
            chk("cont_end_idle", 32'({gpio_we, rdy1, rdy0}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
